reg_rom_ctrl: RTL

Register-bus slave that serves read-only boot memory behind the AXI-to-regbus bridge, replacing the ad-hoc reg-to-mem shim and its hand-written response flops. It issues a single-cycle request to a synchronous ROM with a configurable read latency and returns data on the regbus. It answers writes and out-of-range accesses with an error, and keeps a one-word last-read buffer so repeated fetches of the same word skip the ROM.

---
 rtl/reg_rom_ctrl_pkg.sv | 27 ++
 rtl/reg_rom_lastbuf.sv | 56 +++++
 rtl/reg_rom_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_rom_ctrl_pkg.sv
// Shared definitions for the boot-ROM regbus slave: bus widths, the ROM base
// address on the regbus and the regbus request/response record layouts.
package reg_rom_ctrl_pkg;

    localparam int unsigned RegAddrWidth = 48;
    localparam int unsigned RegDataWidth = 32;

    // Where the boot ROM sits in the regbus address map.
    localparam logic [RegAddrWidth-1:0] BootromBase = 48'h0000_0200_0000;

    // Regbus request as produced by the AXI-to-regbus bridge.
    typedef struct packed {
        logic [RegAddrWidth-1:0]   addr;
        logic                      write;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
        logic                      valid;
    } reg_req_t;

    // Regbus response returned to the bridge.
    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_rom_lastbuf.sv
// One-word last-read buffer: remembers the most recent ROM word (tag + data)
// so a repeated fetch of the same word can be answered without the ROM.
module reg_rom_lastbuf
    import reg_rom_ctrl_pkg::*;
#(
    parameter int unsigned TagWidth  = 14,
    parameter int unsigned DataWidth = RegDataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 fill_i,
    input  logic [TagWidth-1:0]  fill_tag_i,
    input  logic [DataWidth-1:0] fill_data_i,
    input  logic [TagWidth-1:0]  lookup_tag_i,
    output logic                 hit_o,
    output logic [DataWidth-1:0] data_o
);

    logic                 valid_q, valid_d;
    logic [TagWidth-1:0]  tag_q, tag_d;
    logic [DataWidth-1:0] data_q, data_d;

    // Next-state: a flush always wins over a simultaneous fill, so the entry
    // ends up invalid even though the fetched word is still returned upstream.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/reg_rom_ctrl.sv
// Regbus slave in front of a synchronous boot ROM. Reads go to the ROM with a
// fixed latency (or hit the last-word buffer); writes and accesses outside the
// ROM window get an error response. One transaction per pass through IDLE.
module reg_rom_ctrl
    import reg_rom_ctrl_pkg::*;
#(
    parameter int unsigned          AddrWidth    = RegAddrWidth,
    parameter int unsigned          DataWidth    = RegDataWidth,
    parameter logic [AddrWidth-1:0] BaseAddr     = BootromBase,
    parameter int unsigned          RomAddrWidth = 16,
    parameter int unsigned          RomLatency   = 1,
    parameter bit                   UseLastBuf   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [AddrWidth-1:0]    reg_addr_i,
    input  logic [DataWidth-1:0]    reg_wdata_i,
    input  logic [DataWidth/8-1:0]  reg_wstrb_i,
    output logic                    reg_ready_o,
    output logic [DataWidth-1:0]    reg_rdata_o,
    output logic                    reg_error_o,
    output logic                    rom_req_o,
    output logic [RomAddrWidth-1:0] rom_addr_o,
    input  logic [DataWidth-1:0]    rom_data_i,
    output logic                    busy_o
);

    localparam int unsigned WordAddrWidth = RomAddrWidth - 2;
    localparam int unsigned CntWidth      = (RomLatency < 2) ? 1 : $clog2(RomLatency + 1);

    // Window bounds carried one bit wider so a ROM at the top of the address
    // space does not wrap its upper bound to zero.
    localparam logic [AddrWidth:0] RangeLo = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0] RomSize = {{AddrWidth{1'b0}}, 1'b1} << RomAddrWidth;
    localparam logic [AddrWidth:0] RangeHi = RangeLo + RomSize;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StResp,
        StHit,
        StErr
    } state_e;

    state_e                   state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [WordAddrWidth-1:0] waddr_q, waddr_d;
    logic [DataWidth-1:0]     data_q, data_d;

    logic [AddrWidth:0]       addr_ext;
    logic [AddrWidth-1:0]     offset;
    logic [WordAddrWidth-1:0] word_addr;
    logic                     in_range;
    logic                     buf_hit;
    logic [DataWidth-1:0]     buf_data;
    logic                     lookup_hit;
    logic                     fill;
    logic                     rom_req;
    logic                     unused_inputs;

    assign addr_ext  = {1'b0, reg_addr_i};
    assign in_range  = (addr_ext >= RangeLo) && (addr_ext < RangeHi);
    assign offset    = reg_addr_i - BaseAddr;
    assign word_addr = offset[RomAddrWidth-1:2];

    // Write data/strobes are meaningless for a ROM; offset bits outside the
    // word index are covered by the range check.
    assign unused_inputs = ^{reg_wdata_i, reg_wstrb_i,
                             offset[AddrWidth-1:RomAddrWidth], offset[1:0]};

    // The ROM word arrives in the last WAIT cycle; that is also the buffer fill.
    assign fill = (state_q == StWait) && (cnt_q == CntWidth'(1));

    if (UseLastBuf) begin : g_lastbuf
        reg_rom_lastbuf #(
            .TagWidth  (WordAddrWidth),
            .DataWidth (DataWidth)
        ) i_lastbuf (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .fill_i       (fill),
            .fill_tag_i   (waddr_q),
            .fill_data_i  (rom_data_i),
            .lookup_tag_i (word_addr),
            .hit_o        (buf_hit),
            .data_o       (buf_data)
        );
    end else begin : g_nobuf
        assign buf_hit  = 1'b0;
        assign buf_data = '0;
    end

    // A flush in the same cycle as the lookup must not be answered from the
    // entry it is about to invalidate.
    assign lookup_hit = buf_hit && !flush_i;

    // FSM next-state and datapath: classify the request in IDLE, count down the
    // ROM latency in WAIT, then spend exactly one cycle in a response state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        rom_req = 1'b0;
        case (state_q)
            StIdle: begin
                if (reg_valid_i) begin
                    waddr_d = word_addr;
                    if (reg_write_i || !in_range) begin
                        state_d = StErr;
                    end else if (lookup_hit) begin
                        data_d  = buf_data;
                        state_d = StHit;
                    end else begin
                        rom_req = 1'b1;
                        cnt_d   = CntWidth'(RomLatency);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntWidth'(1);
                if (cnt_q == CntWidth'(1)) begin
                    data_d  = rom_data_i;
                    state_d = StResp;
                end
            end
            StResp, StHit, StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
        end
    end

    // The ROM strobe is decoded from the live request, so it is masked while
    // reset is held to keep every output quiet during reset.
    assign rom_req_o  = rom_req && rst_ni;
    assign rom_addr_o = rom_req_o ? {word_addr, 2'b00} : '0;

    assign reg_ready_o = (state_q == StResp) || (state_q == StHit) || (state_q == StErr);
    assign reg_error_o = (state_q == StErr);
    assign reg_rdata_o = ((state_q == StResp) || (state_q == StHit)) ? data_q : '0;
    assign busy_o      = (state_q != StIdle);

endmodule
